// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA scanout of a 320x240 2bpp frame memory, pixel-doubled and palette-mapped.
// Build option VGA_TESTPATTERN_EN adds a tp_sel input that replaces memory codes with 4 vertical colour bars.
module vga_scanout #(
  parameter int unsigned N        = 32,
  parameter logic [23:0] PAL0     = 24'h000000,
  parameter logic [23:0] PAL1     = 24'hFF0000,
  parameter logic [23:0] PAL2     = 24'h00FF00,
  parameter logic [23:0] PAL3     = 24'hFFFFFF,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef VGA_TESTPATTERN_EN
  input  logic         tp_sel,
`endif
  output logic         mem_enable,
  output logic [N-1:0] mem_address,
  input  logic [N-1:0] mem_data,
  output logic         vga_clk,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic         vga_blank_n,
  output logic [7:0]   vga_r,
  output logic [7:0]   vga_g,
  output logic [7:0]   vga_b,
  output logic         frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned AW       = 16;

  logic          pix_tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          armed;
  logic          h_wrap;
  logic          v_wrap;

  logic [HW-1:0] h_src;
  logic [VW-1:0] v_src;
  logic          active_c;
  logic          hs_n_c;
  logic          vs_n_c;

  logic          hs_s1;
  logic          vs_s1;
  logic          active_s1;
`ifdef VGA_TESTPATTERN_EN
  logic [1:0]    tp_bar_s1;
`endif

  logic [1:0]    idx_c;
  logic [23:0]   rgb_c;
  logic          unused_mem_bits;

  assign h_wrap  = (h_cnt == HW'(H_TOTAL - 1));
  assign v_wrap  = (v_cnt == VW'(V_TOTAL - 1));
  assign vga_clk = pix_tick;

  // Only the low two bits of a read word carry the pixel code.
  assign unused_mem_bits = ^mem_data[N-1:2];

  function automatic logic [23:0] palette(input logic [1:0] code);
    logic [23:0] col;
    col = PAL0;
    case (code)
      2'd0: col = PAL0;
      2'd1: col = PAL1;
      2'd2: col = PAL2;
      2'd3: col = PAL3;
      default: col = PAL0;
    endcase
    return col;
  endfunction

  // Pixel tick and raster counters; counters move only on tick edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_tick <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
    end else begin
      pix_tick <= ~pix_tick;
      if (pix_tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
        end
      end
    end
  end

  // The frame that starts at reset release is announced on the first tick;
  // later frames are announced on the tick that wraps the counters to 0,0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b1;
      frame_start <= 1'b0;
      mem_enable  <= 1'b0;
    end else begin
      mem_enable  <= 1'b0;
      frame_start <= pix_tick & (armed | (h_wrap & v_wrap));
      if (pix_tick) begin
        armed <= 1'b0;
      end
    end
  end

  // Timing decode and clamped source coordinates from the live counters.
  always_comb begin
    h_src    = h_cnt;
    v_src    = v_cnt;
    active_c = 1'b0;
    hs_n_c   = 1'b1;
    vs_n_c   = 1'b1;
    if (h_cnt >= HW'(H_ACTIVE)) begin
      h_src = HW'(H_ACTIVE - 1);
    end
    if (v_cnt >= VW'(V_ACTIVE)) begin
      v_src = VW'(V_ACTIVE - 1);
    end
    active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_n_c   = !((h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END)));
    vs_n_c   = !((v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END)));
  end

  // Stage 1: issue the memory read and carry the decoded timing alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
      hs_s1       <= 1'b1;
      vs_s1       <= 1'b1;
      active_s1   <= 1'b0;
`ifdef VGA_TESTPATTERN_EN
      tp_bar_s1   <= 2'd0;
`endif
    end else if (pix_tick) begin
      mem_address <= N'({AW'(v_src >> 1), AW'(h_src >> 1)});
      hs_s1       <= hs_n_c;
      vs_s1       <= vs_n_c;
      active_s1   <= active_c;
`ifdef VGA_TESTPATTERN_EN
      tp_bar_s1   <= h_cnt[7:6];
`endif
    end
  end

  // Colour index: memory code, or the bar index when the test pattern is selected.
  always_comb begin
    idx_c = mem_data[1:0];
`ifdef VGA_TESTPATTERN_EN
    if (tp_sel) begin
      idx_c = tp_bar_s1;
    end
`endif
    rgb_c = active_s1 ? palette(idx_c) : 24'h000000;
  end

  // Stage 2: read data has landed mid-period; drive sync and colour together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else if (pix_tick) begin
      vga_hs      <= hs_s1;
      vga_vs      <= vs_s1;
      vga_blank_n <= active_s1;
      vga_r       <= rgb_c[23:16];
      vga_g       <= rgb_c[15:8];
      vga_b       <= rgb_c[7:0];
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a reference model of the raster predicts every tick's outputs.
// Vertical timing is shortened so full frames (including the end-of-frame wrap) fit a short run.
module tb_vga_scanout;

  localparam int unsigned N = 32;
  localparam int H_A = 640, H_FP = 16, H_S = 96, H_B = 48;
  localparam int V_A = 8, V_FP = 2, V_S = 2, V_B = 3;
  localparam int H_T = H_A + H_FP + H_S + H_B;
  localparam int V_T = V_A + V_FP + V_S + V_B;
  localparam int F_T = H_T * V_T;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_enable;
  logic [N-1:0] mem_address;
  logic [N-1:0] mem_data = '0;
  logic         vga_clk, vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [7:0]   vga_r, vga_g, vga_b;
  bit           tp_mode = 1'b0;
`ifdef VGA_TESTPATTERN_EN
  logic         tp_sel;
  assign tp_sel = tp_mode;
`endif

  always #10 clk = ~clk;

  vga_scanout #(
    .N(N), .H_ACTIVE(H_A), .H_FP(H_FP), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_FP), .V_SYNC(V_S), .V_BP(V_B)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef VGA_TESTPATTERN_EN
    .tp_sel(tp_sel),
`endif
    .mem_enable(mem_enable),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .vga_clk(vga_clk),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .frame_start(frame_start)
  );

  typedef struct {
    int          k;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic        chk_addr;
    logic [23:0] rgb;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  mem_codes [0:239][0:319];
  logic [23:0] pal [0:3] = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFFFF};
  int          checks = 0;
  int          failures = 0;
  int          e = 0;
  bit          run = 1'b0;
  logic [15:0] mx, my;
  logic [1:0]  mcode;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s tick=%0d actual=%0h required=%0h", name, k, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hs"}, 0, 32'(vga_hs), 32'd1);
    check({tag, "_vs"}, 0, 32'(vga_vs), 32'd1);
    check({tag, "_blank_n"}, 0, 32'(vga_blank_n), 32'd0);
    check({tag, "_rgb"}, 0, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check({tag, "_mem_enable"}, 0, 32'(mem_enable), 32'd0);
    check({tag, "_frame_start"}, 0, 32'(frame_start), 32'd0);
    check({tag, "_mem_address"}, 0, mem_address, 32'd0);
    check({tag, "_vga_clk"}, 0, 32'(vga_clk), 32'd0);
  endtask

  // Outputs after the k-th tick following release: the raster position counted
  // from 0 at release is k-1 for the read address and k-2 for what is displayed.
  function automatic exp_t model(input int k, input bit tp);
    exp_t x;
    int   p, h, v, code;
    bit   act;
    x.k        = k;
    x.fs       = (k == 1) || (k % F_T == 0);
    p          = k - 1;
    h          = p % H_T;
    v          = (p / H_T) % V_T;
    x.chk_addr = (h < H_A) && (v < V_A);
    x.addr     = {16'(v / 2), 16'(h / 2)};
    x.hs       = 1'b1;
    x.vs       = 1'b1;
    x.blank    = 1'b0;
    x.rgb      = 24'h0;
    if (k >= 2) begin
      p       = k - 2;
      h       = p % H_T;
      v       = (p / H_T) % V_T;
      act     = (h < H_A) && (v < V_A);
      x.hs    = !(h >= H_A + H_FP && h < H_A + H_FP + H_S);
      x.vs    = !(v >= V_A + V_FP && v < V_A + V_FP + V_S);
      x.blank = act;
      if (act) begin
        code  = tp ? (h / 64) % 4 : int'(mem_codes[v / 2][h / 2]);
        x.rgb = pal[code];
      end
    end
    return x;
  endfunction

  // Frame memory: synchronous read, junk in the unused upper bits.
  always @(posedge clk) begin
    mx = mem_address[15:0];
    my = mem_address[31:16];
    if (mx < 16'd320 && my < 16'd240) mcode = mem_codes[my][mx];
    else mcode = 2'($urandom);
    mem_data <= {30'($urandom), mcode};
  end

  // Producer: each tick edge after release pushes the model's prediction.
  always @(posedge clk) begin
    if (!run) e = 0;
    else begin
      e++;
      if (e % 2 == 0) exp_q.push_back(model(e / 2, tp_mode));
    end
  end

  // Per-clock checks on the pixel clock, write enable and idle frame_start.
  always @(negedge clk) begin
    if (run && rst_n && e > 0) begin
      check("vga_clk", e, 32'(vga_clk), 32'(e % 2));
      check("mem_enable", e, 32'(mem_enable), 32'd0);
      if (e % 2 == 1) check("frame_start_idle", e, 32'(frame_start), 32'd0);
    end
  end

  // Monitor: every falling pixel clock marks a fresh output word to score.
  initial begin
    exp_t x;
    forever begin
      @(negedge vga_clk);
      #1;
      if (run && rst_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow output presented with no prediction at e=%0d", e);
        end else begin
          x = exp_q.pop_front();
          check("vga_hs", x.k, 32'(vga_hs), 32'(x.hs));
          check("vga_vs", x.k, 32'(vga_vs), 32'(x.vs));
          check("vga_blank_n", x.k, 32'(vga_blank_n), 32'(x.blank));
          check("rgb", x.k, 32'({vga_r, vga_g, vga_b}), 32'(x.rgb));
          check("frame_start", x.k, 32'(frame_start), 32'(x.fs));
          if (x.chk_addr) check("mem_address", x.k, mem_address, x.addr);
        end
      end
    end
  end

  initial begin
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++)
        mem_codes[y][x] = 2'($urandom);
    for (int x = 0; x < 4; x++) mem_codes[0][x] = 2'(x);

    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_reset("reset");
    end
    rst_n = 1'b1;
    run   = 1'b1;

    // One full frame plus the start of the next, then reset at h=300, v=3.
    repeat (2 * (F_T + 3 * H_T + 300)) @(posedge clk);
    #3;
    run   = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset("midreset");
    repeat (5) begin
      @(negedge clk);
      check_reset("midreset_hold");
    end
`ifdef VGA_TESTPATTERN_EN
    tp_mode = 1'b1;
`endif
    rst_n = 1'b1;
    run   = 1'b1;
    repeat (2 * (2 * H_T + 400)) @(posedge clk);
    @(negedge clk);
    check("sb_backlog", e, 32'(exp_q.size() > 1), 32'd0);
    run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side consumer of the 2-bit-per-pixel frame memory.
- Generates 640x480@60 VGA timing from the 50 MHz system clock using an internal divide-by-2 pixel tick.
- Fetches each 320x240 source pixel through the memory's synchronous read port and doubles it horizontally and vertically.
- Maps each 2-bit code through a 4-entry palette and drives the DAC and sync pins.

Parameters:
- N, 32, memory address/data width; must match the frame memory.
- PAL0, 24'h000000, RGB888 colour for code 0.
- PAL1, 24'hFF0000, RGB888 colour for code 1.
- PAL2, 24'h00FF00, RGB888 colour for code 2.
- PAL3, 24'hFFFFFF, RGB888 colour for code 3.

Ports:
- clk  in  1  system clock, 50 MHz, rising-edge logic.
- rst_n  in  1  asynchronous active-low reset.
- mem_enable  out  1  memory write enable; held 0 so the memory always performs reads.
- mem_address  out  N  {y[15:0], x[15:0]}; x = h_cnt>>1 (0..319), y = v_cnt>>1 (0..239).
- mem_data  in  N  memory read data; only [1:0] is used.
- vga_clk  out  1  pixel clock to the DAC; equals pix_tick.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_blank_n  out  1  high during the active region.
- vga_r  out  8  red.
- vga_g  out  8  green.
- vga_b  out  8  blue.
- frame_start  out  1  one-clk pulse when h_cnt=0 and v_cnt=0 are first reached.

Behaviour:
- **Reset values.** Async reset (rst_n=0) clears:
  - pix_tick=0, h_cnt=0, v_cnt=0, all pipeline registers.
  - Outputs: vga_hs=1, vga_vs=1, vga_blank_n=0, vga_r/g/b=0, frame_start=0, mem_address=0, mem_enable=0.
- **pix_tick.** Toggles every clk. h_cnt advances only on clk edges where pix_tick=1, giving a 25 MHz pixel rate.
- **Counters.**
  - h_cnt counts 0..799 and wraps to 0.
  - On the h wrap, v_cnt increments over 0..524 and wraps to 0.
  - Both wraps in the same tick take h=799, v=524 to 0,0.
- **Timing decode** (from the counters):
  - active = h<640 && v<480.
  - hs_n = !(656<=h<=751).
  - vs_n = !(490<=v<=491).
- **Stage 1** (tick edge T):
  - Register mem_address from the current counters.
  - Register the decoded hs_n, vs_n and active into stage-1 registers.
  - Outside the active region, mem_address holds {y, x} computed from the clamped counters and is don't-care.
- **Memory.** Returns mem_data[1:0] on the next clk rising edge, i.e. mid-period between ticks.
- **Stage 2** (tick edge T+1):
  - vga_hs, vga_vs and vga_blank_n take the stage-1 values.
  - vga_r/g/b = palette[mem_data[1:0]] when stage-1 active=1, else 0.
- **Pipeline latency.** All VGA outputs lag the counters by exactly 2 pixel ticks (4 clk). Sync and colour stay mutually aligned.
- **frame_start.** Asserted for one clk on the tick edge where the counters become 0,0.
- **Mid-operation reset.** Reset asserted mid-frame returns everything to the reset state immediately. The first visible pixel after release is at h=0, v=0 (plus pipeline latency).

Optional Feature:
- Macro: VGA_TESTPATTERN_EN.
- When defined:
  - Adds input tp_sel (1 bit).
  - When tp_sel=1, the stage-2 colour index is h_cnt_s1[7:6] instead of mem_data[1:0]. h_cnt_s1 is the h_cnt registered in stage 1. This gives 4 vertical bars, each 64 source-doubled pixels wide, repeating across the line.
  - Memory addressing is unchanged.
- When undefined:
  - Port tp_sel is absent; the colour index always comes from mem_data.

Test Plan:
- Reset: hold rst_n=0 for 5 clk, then release. Required: vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, mem_enable=0 throughout. frame_start pulses at the first 0,0 tick after release.
- Addressing: step to h=2,v=0 → mem_address=0x00000001. Step to h=639,v=479 → 0x00EF013F. Step to h=5,v=3 → 0x00010002.
- Line timing: vga_hs low for exactly 96 ticks, starting 656+2 ticks after line start. Line period is 800 ticks (1600 clk).
- Frame timing: vga_vs low for exactly 2 lines (1600 ticks), starting at line 490 (+2 tick offset). Frame period is 420000 ticks. Covers the h=799, v=524 → 0,0 wrap.
- Palette: model memory returns codes 0,1,2,3 for x=0..3 on row 0. Required RGB across screen h=0..7 (2-tick lag): 000000 x2, FF0000 x2, 00FF00 x2, FFFFFF x2. Blanking region RGB=0 regardless of mem_data.
- Reset mid-frame at h=300, v=200: outputs return to reset values within the same clk. Counters restart at 0,0. With VGA_TESTPATTERN_EN and tp_sel=1, bars at h=0/64/128/192 give PAL0/1/2/3.
